// File: rtl/instr_dispatch_ctrl.sv
// Instruction dispatch sequencer: pops 64-bit instructions from the instruction FIFO,
// issues them to the feature loader or CLP, and retires them on the matching done pulse.
module instr_dispatch_ctrl #(
    parameter int unsigned OPC_W   = 7,
    parameter int unsigned TIMEOUT = 65535,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             acc_enable,
    input  logic             i_mem_empty,
    output logic             i_mem_rd_enable,
    input  logic [63:0]      i_mem_dout,
    output logic             fetch_instruction_from_ddr,
    output logic             ld_start,
    input  logic             ld_done,
    output logic             clp_start,
    input  logic             clp_done,
    output logic [63:0]      ctr,
    output logic [CNT_W-1:0] instr_cnt,
    output logic             err_flag,
    output logic             CLP_state
);

    localparam int unsigned TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [OPC_W-1:0] OpNop  = OPC_W'(7'h00);
    localparam logic [OPC_W-1:0] OpLoad = OPC_W'(7'h01);
    localparam logic [OPC_W-1:0] OpConv = OPC_W'(7'h02);
    localparam logic [OPC_W-1:0] OpEnd  = OPC_W'(7'h7F);

    typedef enum logic [3:0] {
        StIdle,
        StCheck,
        StFetch,
        StWaitFifo,
        StPop,
        StLatch,
        StDecode,
        StIssueLd,
        StIssueClp,
        StWaitLd,
        StWaitClp,
        StRetire
    } state_e;

    state_e             state_q, state_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [63:0]        ctr_q, ctr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic [OPC_W-1:0]   opcode;
    logic               timed_out;

    assign opcode    = ctr_q[63 -: OPC_W];
    // The timer is zero on the first cycle of a wait, so TIMEOUT-1 marks the last allowed cycle.
    assign timed_out = (tmr_q == TMR_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            tmr_q   <= '0;
            ctr_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            ctr_q   <= ctr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d                    = state_q;
        tmr_d                      = '0;
        ctr_d                      = ctr_q;
        cnt_d                      = cnt_q;
        err_d                      = err_q;
        i_mem_rd_enable            = 1'b0;
        fetch_instruction_from_ddr = 1'b0;
        ld_start                   = 1'b0;
        clp_start                  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (acc_enable) state_d = StCheck;
            end
            StCheck: begin
                state_d = i_mem_empty ? StFetch : StPop;
            end
            StFetch: begin
                fetch_instruction_from_ddr = 1'b1;
                state_d                    = StWaitFifo;
            end
            StWaitFifo: begin
                tmr_d = tmr_q + TMR_W'(1);
                if (!i_mem_empty) begin
                    state_d = StPop;
                end else if (timed_out) begin
                    err_d   = 1'b1;
                    state_d = StRetire;
                end
            end
            StPop: begin
                // Never pop an empty FIFO; re-evaluate instead.
                if (!i_mem_empty) begin
                    i_mem_rd_enable = 1'b1;
                    state_d         = StLatch;
                end else begin
                    state_d = StCheck;
                end
            end
            StLatch: begin
                ctr_d   = i_mem_dout;
                state_d = StDecode;
            end
            StDecode: begin
                case (opcode)
                    OpLoad:       state_d = StIssueLd;
                    OpConv:       state_d = StIssueClp;
                    OpNop, OpEnd: state_d = StRetire;
                    default: begin
                        err_d   = 1'b1;
                        state_d = StRetire;
                    end
                endcase
            end
            StIssueLd: begin
                ld_start = 1'b1;
                state_d  = StWaitLd;
            end
            StIssueClp: begin
                clp_start = 1'b1;
                state_d   = StWaitClp;
            end
            StWaitLd: begin
                tmr_d = tmr_q + TMR_W'(1);
                if (ld_done) begin
                    state_d = StRetire;
                end else if (timed_out) begin
                    err_d   = 1'b1;
                    state_d = StRetire;
                end
            end
            StWaitClp: begin
                tmr_d = tmr_q + TMR_W'(1);
                if (clp_done) begin
                    state_d = StRetire;
                end else if (timed_out) begin
                    err_d   = 1'b1;
                    state_d = StRetire;
                end
            end
            StRetire: begin
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = ((opcode == OpEnd) || !acc_enable) ? StIdle : StCheck;
            end
            default: state_d = StIdle;
        endcase
    end

    assign ctr       = ctr_q;
    assign instr_cnt = cnt_q;
    assign err_flag  = err_q;
    assign CLP_state = (state_q != StIdle);

endmodule

// File: tb/tb_instr_dispatch_ctrl.sv
// Scoreboard bench for instr_dispatch_ctrl: directed instruction streams, a small FIFO model,
// and a monitor that matches every strobe and retirement against queued expectations.
module tb_instr_dispatch_ctrl;

    localparam logic [63:0] W_NOP   = 64'h0000_0000_0000_0011;
    localparam logic [63:0] W_END   = 64'hFE00_0000_0000_0000;
    localparam logic [63:0] W_CONV  = 64'h0400_0000_0000_0001;
    localparam logic [63:0] W_CONV2 = 64'h0400_0000_0000_0010;
    localparam logic [63:0] W_CONV3 = 64'h0500_0000_0000_0020;
    localparam logic [63:0] W_LOAD  = 64'h0200_0000_0000_00AB;
    localparam logic [63:0] W_BAD   = 64'hAA00_0000_0000_0055;

    localparam int KFetch = 0;
    localparam int KLd    = 1;
    localparam int KClp   = 2;
    localparam int KRet   = 3;

    localparam int SelLd   = 0;
    localparam int SelClp  = 1;
    localparam int SelCnt  = 2;
    localparam int SelIdle = 3;
    localparam int SelErr  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        acc_enable;
    logic        i_mem_empty;
    logic        i_mem_rd_enable;
    logic [63:0] i_mem_dout = '0;
    logic        fetch_instruction_from_ddr;
    logic        ld_start;
    logic        ld_done;
    logic        clp_start;
    logic        clp_done;
    logic [63:0] ctr;
    logic [15:0] instr_cnt;
    logic        err_flag;
    logic        CLP_state;

    always #5 clk = ~clk;

    instr_dispatch_ctrl #(
        .OPC_W   (7),
        .TIMEOUT (100),
        .CNT_W   (16)
    ) dut (
        .clk                        (clk),
        .rst                        (rst),
        .acc_enable                 (acc_enable),
        .i_mem_empty                (i_mem_empty),
        .i_mem_rd_enable            (i_mem_rd_enable),
        .i_mem_dout                 (i_mem_dout),
        .fetch_instruction_from_ddr (fetch_instruction_from_ddr),
        .ld_start                   (ld_start),
        .ld_done                    (ld_done),
        .clp_start                  (clp_start),
        .clp_done                   (clp_done),
        .ctr                        (ctr),
        .instr_cnt                  (instr_cnt),
        .err_flag                   (err_flag),
        .CLP_state                  (CLP_state)
    );

    // FIFO model: written by the stimulus (wr_ptr), drained by the DUT (rd_ptr).
    logic [63:0] mem [64];
    logic [5:0]  wr_ptr = '0;
    logic [5:0]  rd_ptr = '0;
    int          pop_cnt = 0;
    int          cyc = 0;

    assign i_mem_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (i_mem_rd_enable && (wr_ptr != rd_ptr)) begin
            i_mem_dout <= mem[rd_ptr];
            rd_ptr     <= rd_ptr + 6'd1;
            pop_cnt    <= pop_cnt + 1;
        end
    end

    typedef struct {
        int          kind;
        logic [63:0] val;
        logic        err;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    task automatic expect_ev(input int kind, input logic [63:0] val, input logic err);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        e.err  = err;
        exp_q.push_back(e);
    endtask

    task automatic take(input int kind, input logic [63:0] val, input logic err);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL sb_unexpected: event kind %0d value 0x%0h, expected no event", kind, val);
        end else begin
            e = exp_q.pop_front();
            chk("sb_kind", 64'(kind), 64'(e.kind));
            chk("sb_value", val, e.val);
            if (kind == KRet) chk("sb_err_at_retire", 64'(err), 64'(e.err));
        end
    endtask

    task automatic monitor();
        logic [15:0] prev_cnt;
        logic [63:0] lat_word;
        int          lat;
        prev_cnt = '0;
        lat_word = '0;
        lat      = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                prev_cnt = '0;
                lat      = 0;
                continue;
            end
            if (lat > 0) begin
                lat--;
                if (lat == 0) chk("pop_to_ctr_latency", ctr, lat_word);
            end
            if (i_mem_rd_enable) begin
                chk("pop_only_when_nonempty", 64'(i_mem_empty), 64'd0);
                lat_word = mem[rd_ptr];
                lat      = 2;
            end
            if (fetch_instruction_from_ddr) take(KFetch, 64'd0, 1'b0);
            if (ld_start)                   take(KLd, ctr, 1'b0);
            if (clp_start)                  take(KClp, ctr, 1'b0);
            if (instr_cnt != prev_cnt) begin
                take(KRet, 64'(instr_cnt), err_flag);
                prev_cnt = instr_cnt;
            end
        end
    endtask

    task automatic wait_until(input int sel, input int tgt, input int bound, input string name,
                              output int waited);
        bit hit;
        hit    = 1'b0;
        waited = 0;
        for (int i = 0; i < bound && !hit; i++) begin
            @(posedge clk);
            #1;
            waited = i + 1;
            case (sel)
                SelLd:   hit = ld_start;
                SelClp:  hit = clp_start;
                SelCnt:  hit = (int'(instr_cnt) == tgt);
                SelIdle: hit = !CLP_state && (exp_q.size() == 0);
                SelErr:  hit = err_flag;
                default: hit = 1'b1;
            endcase
        end
        n_checks++;
        if (hit) n_pass++;
        else $display("FAIL %s: condition not reached within %0d cycles", name, bound);
    endtask

    task automatic push(input logic [63:0] w);
        mem[wr_ptr] = w;
        wr_ptr      = wr_ptr + 6'd1;
    endtask

    task automatic do_reset();
        chk("sb_drained", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        @(negedge clk);
        rst        = 1'b0;
        acc_enable = 1'b0;
        ld_done    = 1'b0;
        clp_done   = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_ctr", ctr, 64'd0);
        chk("reset_instr_cnt", 64'(instr_cnt), 64'd0);
        chk("reset_err_flag", 64'(err_flag), 64'd0);
        chk("reset_strobes_state", 64'({i_mem_rd_enable, fetch_instruction_from_ddr, ld_start,
                                        clp_start, CLP_state}), 64'd0);
        wr_ptr = rd_ptr;
        rst    = 1'b1;
    endtask

    initial begin
        int w, t1, t2, p0;
        rst        = 1'b0;
        acc_enable = 1'b0;
        ld_done    = 1'b0;
        clp_done   = 1'b0;
        fork
            monitor();
        join_none

        // NOP then END: two back-to-back retirements, 5 cycles apart.
        do_reset();
        p0 = pop_cnt;
        push(W_NOP);
        push(W_END);
        expect_ev(KRet, 64'd1, 1'b0);
        expect_ev(KRet, 64'd2, 1'b0);
        acc_enable = 1'b1;
        @(posedge clk);
        #1;
        chk("busy_after_enable", 64'(CLP_state), 64'd1);
        wait_until(SelCnt, 1, 40, "s1_first_retire", w);
        t1 = cyc;
        @(negedge clk);
        acc_enable = 1'b0;
        wait_until(SelCnt, 2, 40, "s1_second_retire", w);
        t2 = cyc;
        chk("nop_throughput_cycles", 64'(t2 - t1), 64'd5);
        wait_until(SelIdle, 0, 20, "s1_idle", w);
        chk("s1_pops", 64'(pop_cnt - p0), 64'd2);
        chk("s1_err_flag", 64'(err_flag), 64'd0);

        // Empty FIFO: one fetch request, then CONV arrives and runs on the CLP.
        do_reset();
        p0 = pop_cnt;
        expect_ev(KFetch, 64'd0, 1'b0);
        acc_enable = 1'b1;
        repeat (10) @(negedge clk);
        push(W_CONV);
        expect_ev(KClp, W_CONV, 1'b0);
        expect_ev(KRet, 64'd1, 1'b0);
        wait_until(SelClp, 0, 40, "s2_clp_start", w);
        @(negedge clk);
        acc_enable = 1'b0;
        repeat (20) @(negedge clk);
        clp_done = 1'b1;
        @(negedge clk);
        clp_done = 1'b0;
        wait_until(SelIdle, 0, 20, "s2_idle", w);
        chk("s2_pops", 64'(pop_cnt - p0), 64'd1);
        chk("s2_instr_cnt", 64'(instr_cnt), 64'd1);

        // LOAD: a stray clp_done while waiting on the loader is ignored.
        do_reset();
        p0 = pop_cnt;
        push(W_LOAD);
        expect_ev(KLd, W_LOAD, 1'b0);
        expect_ev(KRet, 64'd1, 1'b0);
        acc_enable = 1'b1;
        wait_until(SelLd, 0, 40, "s3_ld_start", w);
        @(negedge clk);
        acc_enable = 1'b0;
        @(negedge clk);
        clp_done = 1'b1;
        @(negedge clk);
        clp_done = 1'b0;
        repeat (2) @(negedge clk);
        chk("s3_wrong_done_no_retire", 64'(instr_cnt), 64'd0);
        chk("s3_still_busy", 64'(CLP_state), 64'd1);
        ld_done = 1'b1;
        @(negedge clk);
        ld_done = 1'b0;
        wait_until(SelIdle, 0, 20, "s3_idle", w);
        chk("s3_pops", 64'(pop_cnt - p0), 64'd1);

        // Bad opcode 0x55 then END: sticky error, both retire, no unit started.
        do_reset();
        p0 = pop_cnt;
        push(W_BAD);
        push(W_END);
        expect_ev(KRet, 64'd1, 1'b1);
        expect_ev(KRet, 64'd2, 1'b1);
        acc_enable = 1'b1;
        wait_until(SelCnt, 1, 40, "s4_first_retire", w);
        @(negedge clk);
        acc_enable = 1'b0;
        wait_until(SelIdle, 0, 40, "s4_idle", w);
        chk("s4_err_sticky", 64'(err_flag), 64'd1);
        chk("s4_pops", 64'(pop_cnt - p0), 64'd2);

        // CONV without clp_done: timeout after 100 cycles in the wait, then continue to END.
        do_reset();
        push(W_CONV2);
        push(W_END);
        expect_ev(KClp, W_CONV2, 1'b0);
        expect_ev(KRet, 64'd1, 1'b1);
        expect_ev(KRet, 64'd2, 1'b1);
        acc_enable = 1'b1;
        wait_until(SelClp, 0, 40, "s5_clp_start", w);
        wait_until(SelErr, 0, 200, "s5_err_rise", w);
        chk("timeout_latency", 64'(w), 64'd101);
        wait_until(SelCnt, 1, 10, "s5_retire", w);
        @(negedge clk);
        acc_enable = 1'b0;
        wait_until(SelIdle, 0, 40, "s5_idle", w);
        chk("s5_instr_cnt", 64'(instr_cnt), 64'd2);

        // acc_enable dropped mid-CONV: that CONV retires, the rest stays in the FIFO.
        do_reset();
        p0 = pop_cnt;
        push(W_CONV3);
        push(W_NOP);
        push(W_NOP);
        push(W_END);
        expect_ev(KClp, W_CONV3, 1'b0);
        expect_ev(KRet, 64'd1, 1'b0);
        acc_enable = 1'b1;
        wait_until(SelClp, 0, 40, "s6_clp_start", w);
        @(negedge clk);
        acc_enable = 1'b0;
        repeat (5) @(negedge clk);
        clp_done = 1'b1;
        @(negedge clk);
        clp_done = 1'b0;
        wait_until(SelIdle, 0, 20, "s6_idle", w);
        repeat (5) @(negedge clk);
        chk("s6_fifo_left", 64'(wr_ptr - rd_ptr), 64'd3);
        chk("s6_pops", 64'(pop_cnt - p0), 64'd1);
        chk("s6_idle_state", 64'(CLP_state), 64'd0);
        chk("s6_ctr_held", ctr, W_CONV3);

        // Asynchronous reset while waiting on the loader.
        do_reset();
        push(W_LOAD);
        expect_ev(KLd, W_LOAD, 1'b0);
        acc_enable = 1'b1;
        wait_until(SelLd, 0, 40, "s7_ld_start", w);
        repeat (3) @(negedge clk);
        chk("s7_ctr_before_reset", ctr, W_LOAD);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_ctr", ctr, 64'd0);
        chk("async_rst_state", 64'(CLP_state), 64'd0);
        chk("async_rst_instr_cnt", 64'(instr_cnt), 64'd0);
        chk("async_rst_strobes", 64'({i_mem_rd_enable, fetch_instruction_from_ddr, ld_start,
                                      clp_start, err_flag}), 64'd0);
        @(negedge clk);
        acc_enable = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("final_sb_drained", 64'(exp_q.size()), 64'd0);
        chk("final_idle", 64'(CLP_state), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
